// File: rtl/not_arb_pkg.sv
// not_arb_pkg: shared types and constants for the round-robin inverter arbiter.
// Revision: 1.0
`default_nettype none

package not_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int N_REQ_DEF = 4;
  localparam int ID_W_DEF  = 2;
  localparam int OPCNT_W   = 16;

endpackage

`default_nettype wire

// File: rtl/not_unit.sv
// not_unit: registered inverter; captures operand and owner id on load, result one cycle later.
// Revision: 1.0
`default_nettype none

module not_unit
  import not_arb_pkg::*;
#(
  parameter int ID_W = ID_W_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            a,
  input  logic [ID_W-1:0] id,
  output logic            y,
  output logic [ID_W-1:0] id_q,
  output logic            valid_q
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= 1'b0;
      y       <= 1'b0;
      id_q    <= '0;
    end else begin
      valid_q <= load;
      if (load) begin
        y    <= ~a;
        id_q <= id;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/not_arbiter.sv
// not_arbiter: round-robin arbiter sharing one registered inverter among N_REQ requesters.
// Optional op_count statistics output enabled by macro NOT_ARBITER_STATS_EN. Revision: 1.0
`default_nettype none

module not_arbiter
  import not_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] a_in,
  output logic [N_REQ-1:0] gnt,
  output logic             rsp_valid,
  output logic [ID_W-1:0]  rsp_id,
  output logic             rsp_y,
  output logic             busy
`ifdef NOT_ARBITER_STATS_EN
  ,
  output logic [OPCNT_W-1:0] op_count
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  w_ptr_nxt;
  logic [ID_W-1:0]  w_idx;
  logic             w_found;
  logic             w_a_sel;
  logic [N_REQ-1:0] w_gnt;

  // Two passes: indices at/above the pointer first, then the wrapped-around lower ones.
  always_comb begin
    w_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    w_a_sel = 1'b0;
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!w_found && req[i] && (ID_W'(i) >= r_ptr)) begin
          w_found  = 1'b1;
          w_idx    = ID_W'(i);
          w_a_sel  = a_in[i];
          w_gnt[i] = 1'b1;
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!w_found && req[i]) begin
          w_found  = 1'b1;
          w_idx    = ID_W'(i);
          w_a_sel  = a_in[i];
          w_gnt[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_found) begin
      if (w_idx == ID_W'(N_REQ - 1)) begin
        w_ptr_nxt = '0;
      end else begin
        w_ptr_nxt = w_idx + ID_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|req)  w_state_nxt = RUN;
      RUN:     if (!(|req)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  not_unit #(
    .ID_W (ID_W)
  ) u_not_unit (
    .clock   (clock),
    .reset   (reset),
    .load    (w_found),
    .a       (w_a_sel),
    .id      (w_idx),
    .y       (rsp_y),
    .id_q    (rsp_id),
    .valid_q (rsp_valid)
  );

  assign gnt  = w_gnt;
  assign busy = (r_state == RUN);

`ifdef NOT_ARBITER_STATS_EN
  logic [OPCNT_W-1:0] r_op_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_op_count <= '0;
    end else if (rsp_valid && (r_op_count != {OPCNT_W{1'b1}})) begin
      r_op_count <= r_op_count + OPCNT_W'(1);
    end
  end

  assign op_count = r_op_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_not_arbiter.sv
// tb_not_arbiter: directed vectors for not_arbiter with a response scoreboard.
// Revision: 1.0
`default_nettype none

module tb_not_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req   = 4'b0000;
  logic [3:0] a_in  = 4'b0000;
  logic [3:0] gnt;
  logic       rsp_valid;
  logic [1:0] rsp_id;
  logic       rsp_y;
  logic       busy;
`ifdef NOT_ARBITER_STATS_EN
  logic [15:0] op_count;
`endif

  not_arbiter #(
    .N_REQ (4),
    .ID_W  (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .a_in      (a_in),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .busy      (busy)
`ifdef NOT_ARBITER_STATS_EN
    ,
    .op_count  (op_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] id;
    logic       y;
  } rsp_t;

  rsp_t q[$];
  rsp_t m_e;
  bit   mon_en     = 1'b1;
  int   vectors    = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every response the DUT presents must match the oldest queued expectation.
  always @(posedge clock) begin
    #1;
    if (mon_en) begin
      if (rsp_valid === 1'b1) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 id=%0d, expected no response (t=%0t)", rsp_id, $time);
        end else begin
          m_e = q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(m_e.id));
          chk("rsp_y", 32'(rsp_y), 32'(m_e.y));
        end
      end else if (q.size() != 0) begin
        m_e = q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_rsp: got rsp_valid=%b, expected response id=%0d (t=%0t)", rsp_valid, m_e.id, $time);
      end
    end
  end

  task automatic step(input logic rn, input logic [3:0] rq, input logic [3:0] a,
                      input logic [3:0] eg, input logic eb);
    rsp_t t;
    @(negedge clock);
    reset = rn;
    req   = rq;
    a_in  = a;
    #1;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("busy", 32'(busy), 32'(eb));
    for (int i = 0; i < 4; i++) begin
      if (eg[i]) begin
        t.id = 2'(i);
        t.y  = ~a[i];
        q.push_back(t);
      end
    end
  endtask

  initial begin
    // Reset then idle
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      chk("idle_rsp_id", 32'(rsp_id), 32'd0);
      chk("idle_rsp_y", 32'(rsp_y), 32'd0);
    end

    // Single request to 2 -> ptr 3
    step(1'b1, 4'b0100, 4'b0100, 4'b0100, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1);

    // Wrap-around from ptr 3
    step(1'b1, 4'b1001, 4'b1000, 4'b1000, 1'b0);
    step(1'b1, 4'b1001, 4'b0001, 4'b0001, 1'b1);
    step(1'b1, 4'b1001, 4'b0000, 4'b1000, 1'b1);
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1);

    // Full contention from ptr 0
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 4'b1111, 4'b0101, 4'(1 << (k % 4)), (k != 0));
    end
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1);

    // Single requester held high -> granted every cycle, ptr ends at 3
    step(1'b1, 4'b0100, 4'b0100, 4'b0100, 1'b0);
    step(1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b1);
    step(1'b1, 4'b0100, 4'b0100, 4'b0100, 1'b1);

    // Requester 1 loses to 0, then drops: no operation for it
    step(1'b1, 4'b0011, 4'b0000, 4'b0001, 1'b1);
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1);

    // Grant to 1 (ptr -> 2), then reset lands on the next grant
    step(1'b1, 4'b0010, 4'b0010, 4'b0010, 1'b0);
    @(negedge clock);
    req  = 4'b0010;
    a_in = 4'b0000;
    #1;
    chk("gnt_pre_reset", 32'(gnt), 32'b0010);
    chk("busy_pre_reset", 32'(busy), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("gnt_in_reset", 32'(gnt), 32'b0000);

    // Release: search restarts at index 0
    step(1'b1, 4'b1111, 4'b1111, 4'b0001, 1'b0);
    chk("rsp_id_after_reset", 32'(rsp_id), 32'd0);
    chk("rsp_valid_after_reset", 32'(rsp_valid), 32'd0);
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    @(negedge clock);
    @(negedge clock);
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL queue_drain: got %0d pending responses, expected 0", q.size());
    end

`ifdef NOT_ARBITER_STATS_EN
    mon_en = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    req   = 4'b0001;
    a_in  = 4'b0000;
    repeat (70000) @(negedge clock);
    #1;
    chk("op_count_sat", 32'(op_count), 32'h0000_FFFF);
    repeat (3) @(negedge clock);
    #1;
    chk("op_count_hold", 32'(op_count), 32'h0000_FFFF);
    @(negedge clock);
    reset = 1'b0;
    req   = 4'b0000;
    @(negedge clock);
    #1;
    chk("op_count_reset", 32'(op_count), 32'd0);
    reset = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/not_arbiter.md
NOT_ARBITER -- requirements
Module: not_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters sharing the one inverter unit (2..8).
REQ-002 Parameter: ID_W, 2, width of the requester index (clog2 of N_REQ, at least 1).
REQ-003 The block SHALL have port `clock`, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port `reset`, input, 1 bit: synchronous, active-low reset (0 = reset, sampled only on the rising edge of `clock`).
REQ-005 The block SHALL have port `req`, input, N_REQ bits: per-requester operation request, level, held until granted.
REQ-006 The block SHALL have port `a_in`, input, N_REQ bits: per-requester operand bit.
REQ-007 The block SHALL have port `gnt`, output, N_REQ bits: one-hot or zero grant, combinational in the same cycle as `req`.
REQ-008 The block SHALL have port `rsp_valid`, output, 1 bit: result valid, one-cycle pulse per completed operation.
REQ-009 The block SHALL have port `rsp_id`, output, ID_W bits: index of the requester owning `rsp_y`.
REQ-010 The block SHALL have port `rsp_y`, output, 1 bit: inverted operand, which is NOT of `a_in[rsp_id]` at grant time.
REQ-011 The block SHALL have port `busy`, output, 1 bit: FSM is in RUN.

Function
REQ-012 FSM states SHALL be IDLE and RUN only.
REQ-013 FSM transitions:
  - IDLE to RUN when |req is 1.
  - RUN stays in RUN while |req is 1.
  - RUN to IDLE when |req is 0.
REQ-014 Arbitration SHALL be round-robin:
  - Search starts at pointer `ptr` (ID_W bits) and wraps N_REQ-1 to 0.
  - The first index i with req[i]=1 gets gnt[i]=1.
  - gnt is all-zero when req is 0.
REQ-015 On any cycle with a grant to i, `ptr` SHALL load (i+1) mod N_REQ; with no grant, `ptr` holds.
REQ-016 On a grant cycle, the inverter unit SHALL capture a_in[i] and i; rsp_valid=1, rsp_id=i, rsp_y=~a_in[i] on the next cycle (latency exactly 1).
REQ-017 Throughput SHALL be one grant per cycle, with back-to-back grants allowed to different or the same requester.
REQ-018 A requester SHALL consider its request accepted in the cycle where gnt[i]=1; it may drop or re-raise req freely afterwards.
REQ-019 A req dropped before grant SHALL be ignored, with no operation and no response.
REQ-020 rsp_valid SHALL be 0 in any cycle not following a grant cycle; rsp_id and rsp_y hold their last values when rsp_valid=0.
REQ-021 A single requester with req held high SHALL be granted every cycle.

Reset
REQ-022 With reset=0 at a rising edge, the following SHALL be cleared: state=IDLE, ptr=0, rsp_valid=0, rsp_id=0, rsp_y=0, busy=0.
REQ-023 gnt SHALL be forced all-zero while reset=0.
REQ-024 Reset mid-operation SHALL discard any in-flight result; no rsp_valid pulse appears for it.
REQ-025 The first grant after reset release SHALL search from index 0.

Configuration
REQ-026 Macro NOT_ARBITER_STATS_EN, when defined, SHALL add output `op_count` (16 bits):
  - Counts rsp_valid pulses and saturates at 16'hFFFF.
  - Cleared by reset.
REQ-027 Without NOT_ARBITER_STATS_EN, `op_count` and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Shared package not_arb_pkg SHALL hold:
  - the FSM state type {IDLE, RUN};
  - default N_REQ and ID_W constants;
  - the op_count width constant (16).
REQ-029 The registered inverter SHALL be a separate sub-module `not_unit`:
  - ports: clock, reset, load, a, id, y, id_q, valid_q;
  - latency is 1 cycle.
REQ-030 The arbiter, pointer and FSM SHALL reside in not_arbiter.

Verification
REQ-031 Reset then idle: reset=0 for 2 cycles, then req=0000 for 5 cycles -> gnt=0000, rsp_valid=0, busy=0, rsp_id=0, rsp_y=0 throughout.
REQ-032 Single request: req=0100, a_in=0100 for one cycle -> gnt=0100 that cycle; next cycle rsp_valid=1, rsp_id=2, rsp_y=0; ptr=3.
REQ-033 Full contention: req=1111 held 8 cycles from ptr=0 -> grants in order 0,1,2,3,0,1,2,3; rsp_id follows one cycle later; busy=1.
REQ-034 Wrap-around: ptr=3, req=1001 -> grant to 3, then 0, then 3.
REQ-035 Reset mid-operation: grant to 1 at cycle t, reset=0 at edge t+1 -> no rsp_valid pulse; ptr=0; first grant after release is to index 0 when req=1111.
REQ-036 With NOT_ARBITER_STATS_EN: 70000 back-to-back grants -> op_count=16'hFFFF, held; reset -> op_count=0.
